// File: rtl/tx_word_scheduler.sv
// Purpose: round-robin share of the 16-bit symbol serializer between two word requesters, LSB first.
// Latency: word accepted at cycle N drives its first symbol over N+1..N+SYM_LEN; 16 (17) symbols per word.
// Backpressure: readyX only in IDLE; requests held through SEND/GAP simply wait. Option macro: TX_PARITY_EN.
module tx_word_scheduler #(
  parameter int SYM_LEN  = 256,
  parameter int PH_W     = 8,
  parameter int GAP_SYMS = 2
) (
  input  logic            clk_sys,
  input  logic            rst_n,
  input  logic            req0_valid,
  input  logic [15:0]     req0_data,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [15:0]     req1_data,
  output logic            req1_ready,
  output logic            tx_bit,
  output logic            tx_active,
  output logic            sym_strobe,
  output logic [PH_W-1:0] phase,
  output logic [4:0]      sign_cnt,
  output logic            grant_id,
  output logic            word_done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

`ifdef TX_PARITY_EN
  // Symbol 16 carries the even parity of the word.
  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] CNT_LAST = 5'd16;
`else
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = 4'd15;
`endif

  localparam logic [PH_W-1:0] PH_LAST  = PH_W'(SYM_LEN - 1);
  localparam logic [15:0]     GAP_LAST = 16'((GAP_SYMS > 0) ? (GAP_SYMS - 1) : 0);

  state_t            state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       gap_q, gap_d;
  logic [15:0]       word_q, word_d;
  logic              bit_q, bit_d;
  logic              grant_q, grant_d;
  logic              rr_q, rr_d;
  logic              phase_last;
  logic              idle_ok;

  // Bit carried by symbol idx of word w (parity symbol when enabled).
  function automatic logic sym_bit(input logic [15:0] w, input logic [CNT_W-1:0] idx);
`ifdef TX_PARITY_EN
    if (idx[4]) begin
      return ^w;
    end
    return w[idx[3:0]];
`else
    return w[idx];
`endif
  endfunction

  assign phase_last = (phase_q == PH_LAST);

  // Combinational ready: only in IDLE (and out of reset); rr pointer breaks ties.
  always_comb begin
    idle_ok    = (state_q == ST_IDLE) && rst_n;
    req0_ready = idle_ok && req0_valid && (!req1_valid || !rr_q);
    req1_ready = idle_ok && req1_valid && (!req0_valid || rr_q);
  end

  // Next-state logic: grant/latch in IDLE, symbol timing in SEND, idle symbols in GAP.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    word_d  = word_q;
    bit_d   = bit_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    unique case (state_q)
      ST_IDLE: begin
        phase_d = '0;
        cnt_d   = '0;
        gap_d   = '0;
        bit_d   = 1'b0;
        if (req0_ready) begin
          word_d  = req0_data;
          bit_d   = req0_data[0];
          grant_d = 1'b0;
          rr_d    = 1'b1;
          state_d = ST_SEND;
        end else if (req1_ready) begin
          word_d  = req1_data;
          bit_d   = req1_data[0];
          grant_d = 1'b1;
          rr_d    = 1'b0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        phase_d = phase_last ? '0 : phase_q + 1'b1;
        if (phase_last) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            bit_d   = 1'b0;
            gap_d   = '0;
            state_d = (GAP_SYMS > 0) ? ST_GAP : ST_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
            bit_d = sym_bit(word_q, cnt_q + 1'b1);
          end
        end
      end
      ST_GAP: begin
        phase_d = phase_last ? '0 : phase_q + 1'b1;
        bit_d   = 1'b0;
        cnt_d   = '0;
        if (phase_last) begin
          if (gap_q == GAP_LAST) begin
            state_d = ST_IDLE;
          end else begin
            gap_d = gap_q + 16'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = '0;
        cnt_d   = '0;
        bit_d   = 1'b0;
      end
    endcase
  end

  // State register; reset aborts any word in flight.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      word_q  <= '0;
      bit_q   <= 1'b0;
      grant_q <= 1'b0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      word_q  <= word_d;
      bit_q   <= bit_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
    end
  end

  assign tx_bit     = bit_q;
  assign tx_active  = (state_q == ST_SEND);
  assign sym_strobe = tx_active && (phase_q == '0);
  assign word_done  = tx_active && phase_last && (cnt_q == CNT_LAST);
  assign phase      = phase_q;
  assign grant_id   = grant_q;
`ifdef TX_PARITY_EN
  assign sign_cnt   = cnt_q;
`else
  assign sign_cnt   = {1'b0, cnt_q};
`endif

endmodule

// File: tb/tb_tx_word_scheduler.sv
// Purpose: directed self-checking bench for tx_word_scheduler (SYM_LEN=4; GAP_SYMS=2 and GAP_SYMS=0 instances).
// Latency: samples on the falling edge; k counts falling edges after the accepting rising edge.
// Backpressure: exercises ready during SEND/GAP, contention and back-to-back streaming.
module tb_tx_word_scheduler;

`ifdef TX_PARITY_EN
  localparam int NSYM = 17;
`else
  localparam int NSYM = 16;
`endif
  localparam int SL   = 4;
  localparam int WCYC = NSYM * SL;
  localparam int GCYC = 2 * SL;

  logic        clk;
  logic        rst_n;
  logic        r0v, r1v, r0_rdy, r1_rdy;
  logic [15:0] r0d, r1d;
  logic        tx_bit, tx_active, sym_strobe, grant_id, word_done;
  logic [7:0]  phase;
  logic [4:0]  sign_cnt;

  logic        b_r0v, b_r1v, b_r0_rdy, b_r1_rdy;
  logic [15:0] b_r0d, b_r1d;
  logic        b_tx_bit, b_tx_active, b_sym_strobe, b_grant_id, b_word_done;
  logic [7:0]  b_phase;
  logic [4:0]  b_sign_cnt;

  int checks;
  int failures;

  tx_word_scheduler #(.SYM_LEN(SL), .PH_W(8), .GAP_SYMS(2)) dut (
    .clk_sys(clk), .rst_n(rst_n),
    .req0_valid(r0v), .req0_data(r0d), .req0_ready(r0_rdy),
    .req1_valid(r1v), .req1_data(r1d), .req1_ready(r1_rdy),
    .tx_bit(tx_bit), .tx_active(tx_active), .sym_strobe(sym_strobe),
    .phase(phase), .sign_cnt(sign_cnt), .grant_id(grant_id), .word_done(word_done)
  );

  tx_word_scheduler #(.SYM_LEN(SL), .PH_W(8), .GAP_SYMS(0)) dut0 (
    .clk_sys(clk), .rst_n(rst_n),
    .req0_valid(b_r0v), .req0_data(b_r0d), .req0_ready(b_r0_rdy),
    .req1_valid(b_r1v), .req1_data(b_r1d), .req1_ready(b_r1_rdy),
    .tx_bit(b_tx_bit), .tx_active(b_tx_active), .sym_strobe(b_sym_strobe),
    .phase(b_phase), .sign_cnt(b_sign_cnt), .grant_id(b_grant_id), .word_done(b_word_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected symbol bit: data bits LSB first, then even parity.
  function automatic logic exp_bit(input logic [15:0] d, input int s);
    if (s < 16) return d[s];
    return ^d;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    r0v = 1'b0; r1v = 1'b0; b_r0v = 1'b0; b_r1v = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    r0v = 1'b1; r1v = 1'b1; r0d = 16'h1111; r1d = 16'h2222;
    b_r0v = 1'b0; b_r1v = 1'b0; b_r0d = 16'h0; b_r1d = 16'h0;
    @(negedge clk);
    checks++; if (r0_rdy !== 1'b0 || r1_rdy !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b%b exp=00", r0_rdy, r1_rdy); end
    checks++; if (tx_bit !== 1'b0 || tx_active !== 1'b0 || sym_strobe !== 1'b0 || word_done !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b%b%b exp=0000", tx_bit, tx_active, sym_strobe, word_done); end
    checks++; if (phase !== 8'd0 || sign_cnt !== 5'd0 || grant_id !== 1'b0) begin failures++; $display("FAIL reset_cnt phase=%0d sign=%0d grant=%b exp=0", phase, sign_cnt, grant_id); end
    r0v = 1'b0; r1v = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (tx_active !== 1'b0 || phase !== 8'd0 || r0_rdy !== 1'b0) begin failures++; $display("FAIL reset_idle act=%b phase=%0d rdy=%b exp=0", tx_active, phase, r0_rdy); end
  endtask

  task automatic test_single();
    logic [15:0] d;
    d = 16'hA5C3;
    r0d = d; r0v = 1'b1;
    #1;
    checks++; if (r0_rdy !== 1'b1 || r1_rdy !== 1'b0) begin failures++; $display("FAIL single_ready got=%b%b exp=10", r0_rdy, r1_rdy); end
    @(posedge clk);
    for (int k = 0; k < WCYC + GCYC; k++) begin
      @(negedge clk);
      if (k == 0) r0v = 1'b0;
      if (k < WCYC) begin
        checks++; if (tx_bit !== exp_bit(d, k / SL)) begin failures++; $display("FAIL single_bit k=%0d got=%b exp=%b", k, tx_bit, exp_bit(d, k / SL)); end
        checks++; if (tx_active !== 1'b1 || sym_strobe !== (k % SL == 0) || word_done !== (k == WCYC - 1)) begin failures++; $display("FAIL single_flags k=%0d act=%b strb=%b done=%b", k, tx_active, sym_strobe, word_done); end
        checks++; if (phase !== 8'(k % SL) || sign_cnt !== 5'(k / SL) || grant_id !== 1'b0) begin failures++; $display("FAIL single_cnt k=%0d phase=%0d sign=%0d grant=%b", k, phase, sign_cnt, grant_id); end
      end else begin
        checks++; if (tx_active !== 1'b0 || tx_bit !== 1'b0 || word_done !== 1'b0 || sign_cnt !== 5'd0 || phase !== 8'((k - WCYC) % SL)) begin failures++; $display("FAIL single_gap k=%0d act=%b bit=%b done=%b sign=%0d phase=%0d", k, tx_active, tx_bit, word_done, sign_cnt, phase); end
      end
    end
    @(negedge clk);
    checks++; if (tx_active !== 1'b0 || phase !== 8'd0 || sign_cnt !== 5'd0) begin failures++; $display("FAIL single_idle act=%b phase=%0d sign=%0d exp=0", tx_active, phase, sign_cnt); end
  endtask

  task automatic test_contention();
    logic [15:0] d0, d1;
    d0 = 16'h0001; d1 = 16'h8000;
    do_reset();
    r0d = d0; r1d = d1; r0v = 1'b1; r1v = 1'b1;
    #1;
    checks++; if (r0_rdy !== 1'b1 || r1_rdy !== 1'b0) begin failures++; $display("FAIL cont_first got=%b%b exp=10", r0_rdy, r1_rdy); end
    @(posedge clk);
    for (int k = 0; k < WCYC + GCYC; k++) begin
      @(negedge clk);
      if (k == 0) r0v = 1'b0;
      checks++; if (r1_rdy !== 1'b0) begin failures++; $display("FAIL cont_wait k=%0d got=%b exp=0", k, r1_rdy); end
      if (k < WCYC) begin
        checks++; if (tx_bit !== exp_bit(d0, k / SL) || grant_id !== 1'b0) begin failures++; $display("FAIL cont_w0 k=%0d bit=%b grant=%b", k, tx_bit, grant_id); end
      end
    end
    @(negedge clk);
    checks++; if (r1_rdy !== 1'b1 || r0_rdy !== 1'b0) begin failures++; $display("FAIL cont_second got=%b%b exp=01", r0_rdy, r1_rdy); end
    @(posedge clk);
    for (int k = 0; k < WCYC + GCYC; k++) begin
      @(negedge clk);
      if (k == 0) r1v = 1'b0;
      if (k < WCYC) begin
        checks++; if (tx_bit !== exp_bit(d1, k / SL) || grant_id !== 1'b1) begin failures++; $display("FAIL cont_w1 k=%0d bit=%b grant=%b", k, tx_bit, grant_id); end
      end
    end
    @(negedge clk);
    r0v = 1'b1; r1v = 1'b1;
    #1;
    checks++; if (r0_rdy !== 1'b1 || r1_rdy !== 1'b0) begin failures++; $display("FAIL cont_third got=%b%b exp=10", r0_rdy, r1_rdy); end
    @(posedge clk);
    @(negedge clk);
    r0v = 1'b0; r1v = 1'b0;
    checks++; if (grant_id !== 1'b0 || tx_active !== 1'b1) begin failures++; $display("FAIL cont_third_grant grant=%b act=%b exp=0,1", grant_id, tx_active); end
  endtask

  task automatic test_hold_busy();
    do_reset();
    r0d = 16'h1234; r0v = 1'b1;
    @(posedge clk);
    for (int k = 0; k < WCYC + GCYC; k++) begin
      @(negedge clk);
      if (k == 0) r0v = 1'b0;
      if (k == 10) begin r1v = 1'b1; r1d = 16'hFFFF; end
      if (k >= 10) begin
        checks++; if (r1_rdy !== 1'b0) begin failures++; $display("FAIL hold_ready k=%0d got=%b exp=0", k, r1_rdy); end
      end
    end
    @(negedge clk);
    checks++; if (r1_rdy !== 1'b1) begin failures++; $display("FAIL hold_idle_ready got=%b exp=1", r1_rdy); end
    @(posedge clk);
    for (int k = 0; k < WCYC; k++) begin
      @(negedge clk);
      if (k == 0) begin r1v = 1'b0; r1d = 16'h0000; end
      checks++; if (tx_bit !== exp_bit(16'hFFFF, k / SL)) begin failures++; $display("FAIL hold_bit k=%0d got=%b exp=%b", k, tx_bit, exp_bit(16'hFFFF, k / SL)); end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    r1d = 16'hA5C3; r1v = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= 30; k++) begin
      @(negedge clk);
      if (k == 0) r1v = 1'b0;
    end
    checks++; if (sign_cnt !== 5'd7 || phase !== 8'd2 || grant_id !== 1'b1 || tx_bit !== 1'b1) begin failures++; $display("FAIL arst_pre sign=%0d phase=%0d grant=%b bit=%b exp=7,2,1,1", sign_cnt, phase, grant_id, tx_bit); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (tx_bit !== 1'b0 || tx_active !== 1'b0 || sym_strobe !== 1'b0 || word_done !== 1'b0 || grant_id !== 1'b0) begin failures++; $display("FAIL arst_now bit=%b act=%b strb=%b done=%b grant=%b exp=0", tx_bit, tx_active, sym_strobe, word_done, grant_id); end
    checks++; if (phase !== 8'd0 || sign_cnt !== 5'd0) begin failures++; $display("FAIL arst_cnt phase=%0d sign=%0d exp=0", phase, sign_cnt); end
    for (int k = 0; k < 3 * WCYC; k++) begin
      @(negedge clk);
      if (k == 2) rst_n = 1'b1;
      checks++; if (word_done !== 1'b0 || tx_active !== 1'b0 || phase !== 8'd0 || r0_rdy !== 1'b0 || r1_rdy !== 1'b0) begin failures++; $display("FAIL arst_after k=%0d done=%b act=%b phase=%0d rdy=%b%b", k, word_done, tx_active, phase, r0_rdy, r1_rdy); end
    end
  endtask

  task automatic test_back_to_back();
    int strobes;
    do_reset();
    b_r0d = 16'hA5C3; b_r0v = 1'b1; b_r1v = 1'b0; b_r1d = 16'h0;
    #1;
    checks++; if (b_r0_rdy !== 1'b1) begin failures++; $display("FAIL b2b_ready0 got=%b exp=1", b_r0_rdy); end
    @(posedge clk);
    for (int w = 0; w < 2; w++) begin
      strobes = 0;
      for (int k = 0; k < WCYC; k++) begin
        @(negedge clk);
        if (b_sym_strobe === 1'b1) strobes++;
        checks++; if (b_tx_active !== 1'b1 || b_r0_rdy !== 1'b0 || b_word_done !== (k == WCYC - 1)) begin failures++; $display("FAIL b2b_send w=%0d k=%0d act=%b rdy=%b done=%b", w, k, b_tx_active, b_r0_rdy, b_word_done); end
      end
      checks++; if (strobes !== NSYM) begin failures++; $display("FAIL b2b_strobes w=%0d got=%0d exp=%0d", w, strobes, NSYM); end
      @(negedge clk);
      checks++; if (b_tx_active !== 1'b0 || b_r0_rdy !== 1'b1) begin failures++; $display("FAIL b2b_idle w=%0d act=%b rdy=%b exp=0,1", w, b_tx_active, b_r0_rdy); end
      @(posedge clk);
    end
    @(negedge clk);
    checks++; if (b_tx_active !== 1'b1 || b_sym_strobe !== 1'b1) begin failures++; $display("FAIL b2b_restart act=%b strb=%b exp=1,1", b_tx_active, b_sym_strobe); end
    b_r0v = 1'b0;
  endtask

`ifdef TX_PARITY_EN
  task automatic test_parity();
    do_reset();
    r0d = 16'h0007; r0v = 1'b1;
    @(posedge clk);
    for (int k = 0; k < WCYC; k++) begin
      @(negedge clk);
      if (k == 0) r0v = 1'b0;
      if (k >= 64) begin
        checks++; if (tx_bit !== 1'b1 || sign_cnt !== 5'd16 || word_done !== (k == 67)) begin failures++; $display("FAIL parity k=%0d bit=%b sign=%0d done=%b", k, tx_bit, sign_cnt, word_done); end
      end else begin
        checks++; if (word_done !== 1'b0) begin failures++; $display("FAIL parity_early k=%0d done=%b exp=0", k, word_done); end
      end
    end
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_single();
    test_contention();
    test_hold_busy();
    test_async_reset();
    test_back_to_back();
`ifdef TX_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tx_word_scheduler.md
Name: tx_word_scheduler

Overview:
- Shares the 16-bit symbol serializer between two word requesters (e.g. CRC encoder output and a test-pattern source).
- Arbitrates round-robin and latches the granted 16-bit codeword.
- Generates phase/symbol timing and drives one bit per symbol period, LSB first.
- Sits between the CRC encoders and the 4FSK modulator; paces all transmit traffic.

Parameters:
SYM_LEN, 256, clk_sys cycles per symbol (>=2); phase counts 0..SYM_LEN-1.
PH_W, 8, width of phase counter (must hold SYM_LEN-1).
GAP_SYMS, 2, idle symbol periods inserted after each word (0 allowed).

Ports:
clk_sys  in  1  system clock, all logic on rising edge.
rst_n  in  1  reset; asynchronous, active-low.
req0_valid  in  1  requester 0 has a word.
req0_data  in  16  requester 0 codeword.
req0_ready  out  1  requester 0 word accepted this cycle when valid&ready.
req1_valid  in  1  requester 1 has a word.
req1_data  in  16  requester 1 codeword.
req1_ready  out  1  requester 1 accept.
tx_bit  out  1  serial bit to modulator.
tx_active  out  1  high while a word's symbols are driven.
sym_strobe  out  1  high on the first cycle of each transmitted symbol (phase==0 in SEND).
phase  out  PH_W  cycle index within current symbol.
sign_cnt  out  5  symbol index within word (0..15, 16 if parity enabled).
grant_id  out  1  requester owning the current/last word.
word_done  out  1  one-cycle pulse on the last cycle of a word's final symbol.

Behaviour:
- Reset (rst_n low, async): state IDLE, phase=0, sign_cnt=0, shift word=0, tx_bit=0, tx_active=0, sym_strobe=0, word_done=0, grant_id=0, rr pointer=0 (req0 preferred), both ready=0.
- States: IDLE, SEND, GAP.
- IDLE:
  - Ready is combinational: with one valid, that requester's ready=1. With both valid, the requester matching the rr pointer gets ready=1, the other 0. No valid: both ready=0.
  - On valid&ready: latch data, grant_id=winner, rr pointer=~winner, phase=0, sign_cnt=0, next state SEND.
  - Ready is never asserted outside IDLE.
- SEND:
  - tx_active=1; tx_bit=word[sign_cnt] (bit 0 first), registered so it is stable for the whole symbol.
  - phase increments each cycle. At phase==SYM_LEN-1: phase wraps to 0 and sign_cnt increments.
  - At phase==SYM_LEN-1 with sign_cnt==last index (15, or 16 with parity): word_done=1 for that cycle. Next state is GAP if GAP_SYMS>0, else IDLE.
  - Latency: accept at cycle N; first symbol spans cycles N+1..N+SYM_LEN; whole word is 16*SYM_LEN cycles.
- GAP:
  - tx_bit=0, tx_active=0, phase keeps counting, sign_cnt=0.
  - Lasts GAP_SYMS*SYM_LEN cycles, then IDLE.
  - Requests held during GAP wait; valid may stay high with ready low. No data loss.
- Back-to-back (GAP_SYMS=0): IDLE lasts at least one cycle between words, so there is a 1-cycle idle gap.
- Valid deasserting while not ready: allowed; no grant and no pointer change.
- Input changes during SEND do not affect the latched word.
- Reset mid-word: immediate abort; outputs return to reset values; no word_done.
- phase and sign_cnt hold 0 in IDLE.

Optional Feature:
TX_PARITY_EN:
- Defined: after bit 15, one extra symbol (sign_cnt=16) carries the even parity bit (XOR of all 16 bits). word_done fires at the end of symbol 16. Word length is 17*SYM_LEN cycles.
- Undefined: 16 symbols only; sign_cnt never exceeds 15, and its MSB is tied 0.

Test Plan (SYM_LEN=4, GAP_SYMS=2 unless noted):
- Single word: req0_valid with 16'hA5C3; ready pulses once → tx_bit sequence 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1, each held 4 cycles. word_done at cycle 64 after accept. 8 idle cycles, then IDLE.
- Contention: both valid from reset, req0=16'h0001, req1=16'h8000 → req0 granted first (grant_id=0), req1 after gap (grant_id=1). Third simultaneous request goes to req0 again.
- Hold during busy: req1 raises valid mid-SEND with 16'hFFFF → req1_ready stays 0 until IDLE. Word is then sent intact: tx_bit=1 for 64 cycles.
- Async reset: assert rst_n low at sign_cnt=7, phase=2 → all outputs 0 immediately, no word_done. After release with no valid, stays IDLE.
- GAP_SYMS=0 back-to-back: req0 continuously valid → successive words separated by exactly one IDLE cycle. sym_strobe count = 16 per word.
- TX_PARITY_EN with 16'h0007 → 17 symbols, last symbol tx_bit=1; word_done at cycle 68.
